// File: rtl/crc_pkg.sv
// crc_pkg: shared constants for the CRC-8 frame generator.
//   CRC8_POLY_DEFAULT : default generator polynomial, MSB-first, implicit x^8
//   IDLE/PAYLOAD/CRC  : frame FSM state encoding
package crc_pkg;

   localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;

   typedef logic [1:0] state_t;

   localparam state_t IDLE    = 2'd0;
   localparam state_t PAYLOAD = 2'd1;
   localparam state_t CRC     = 2'd2;

endpackage

// File: rtl/crc8_byte_step.sv
// crc8_byte_step: combinational CRC-8 update over one data byte,
// processed MSB-first, non-reflected.
//   crc_in  [7:0] : CRC register before the byte
//   d       [7:0] : data byte
//   crc_out [7:0] : CRC register after all 8 bits of d
module crc8_byte_step
   import crc_pkg::*;
#(
   parameter logic [7:0] POLY = CRC8_POLY_DEFAULT
) (
   input  logic [7:0] crc_in,
   input  logic [7:0] d,
   output logic [7:0] crc_out
);

   always_comb begin
      logic [7:0] c;
      logic       fb;
      c  = crc_in;
      fb = 1'b0;
      // Unrolled bit-serial LFSR: data enters MSB first.
      for (int i = 0; i < 8; i++) begin
         fb = c[7] ^ d[3'(7 - i)];
         c  = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
      end
      crc_out = c;
   end

endmodule

// File: rtl/crc8_frame_gen.sv
// crc8_frame_gen: transmit-side CRC-8 framer. Forwards each payload byte
// and appends the CRC of the frame as its final byte.
//   CLK, RST          : clock (rising edge), asynchronous active-low reset
//   din, D_VALID,
//   D_LAST, D_READY   : input byte stream; D_LAST marks the final payload byte
//   dout, DOUT_VALID,
//   DOUT_LAST,
//   DOUT_READY        : output byte stream; DOUT_LAST marks the CRC byte
//   frames            : count of CRC bytes accepted downstream (wraps)
module crc8_frame_gen
   import crc_pkg::*;
#(
   parameter logic [7:0] POLY    = CRC8_POLY_DEFAULT,
   parameter logic [7:0] INIT    = 8'h00,
   parameter logic [7:0] XOR_OUT = 8'h00
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] din,
   input  logic       D_VALID,
   input  logic       D_LAST,
   output logic       D_READY,
   output logic [7:0] dout,
   output logic       DOUT_VALID,
   output logic       DOUT_LAST,
   input  logic       DOUT_READY,
   output logic [7:0] frames
);

   state_t     state_q, state_d;
   logic [7:0] crc_q, crc_d;
   logic [7:0] dout_q, dout_d;
   logic       dout_valid_q, dout_valid_d;
   logic       dout_last_q, dout_last_d;
   logic [7:0] frames_q, frames_d;

   logic       slot_free;
   logic       in_xfer;
   logic       out_xfer;
   logic [7:0] crc_base;
   logic [7:0] crc_next;

   // The single output register can take a new byte when empty or draining.
   assign slot_free = !dout_valid_q | DOUT_READY;
   // RST gates D_READY so nothing is offered as accepted while held in reset.
   assign D_READY   = RST & (state_q != CRC) & slot_free;
   assign in_xfer   = D_VALID & D_READY;
   assign out_xfer  = dout_valid_q & DOUT_READY;

   // First byte of a frame always starts from INIT.
   assign crc_base  = (state_q == IDLE) ? INIT : crc_q;

   crc8_byte_step #(.POLY(POLY)) u_step (
      .crc_in  (crc_base),
      .d       (din),
      .crc_out (crc_next)
   );

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, PAYLOAD: begin
            if (in_xfer) begin
               state_d = D_LAST ? CRC : PAYLOAD;
            end
         end
         CRC: begin
            if (slot_free) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      crc_d        = crc_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      dout_last_d  = dout_last_q;
      frames_d     = frames_q;

      if (out_xfer && dout_last_q) begin
         frames_d = frames_q + 8'd1;
      end

      case (state_q)
         IDLE, PAYLOAD: begin
            if (in_xfer) begin
               dout_d       = din;
               dout_valid_d = 1'b1;
               dout_last_d  = 1'b0;
               crc_d        = crc_next;
            end else if (slot_free) begin
               // Previous byte left (or nothing was held): register empties.
               dout_valid_d = 1'b0;
               dout_last_d  = 1'b0;
            end
         end
         CRC: begin
            if (slot_free) begin
               dout_d       = crc_q ^ XOR_OUT;
               dout_valid_d = 1'b1;
               dout_last_d  = 1'b1;
               crc_d        = INIT;
            end
         end
         default: begin
            crc_d = INIT;
         end
      endcase
   end

   // Output register, CRC accumulator and frame counter
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         crc_q        <= INIT;
         dout_q       <= 8'h00;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         frames_q     <= 8'h00;
      end else begin
         crc_q        <= crc_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         dout_last_q  <= dout_last_d;
         frames_q     <= frames_d;
      end
   end

   assign dout       = dout_q;
   assign DOUT_VALID = dout_valid_q;
   assign DOUT_LAST  = dout_last_q;
   assign frames     = frames_q;

endmodule

// File: doc/crc8_frame_gen.md
Name: crc8_frame_gen

Overview:
- Transmit-side CRC-8 generator, sitting directly upstream of the PISO shift register / serial CRC-8 checker path.
- Accepts a byte-wide payload stream framed by a last flag and computes CRC-8 byte-at-a-time.
- Forwards each payload byte, then appends the CRC byte as the frame's final byte.
- Output presents a valid/ready byte handshake matching the shift register's D_VALID/D_READY input.

Parameters:
- POLY, 8'h07, generator polynomial (implicit x^8), MSB-first, non-reflected.
- INIT, 8'h00, CRC register value at the start of each frame.
- XOR_OUT, 8'h00, value XORed into the CRC before it is emitted.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- din  input  8  payload byte.
- D_VALID  input  1  din is valid.
- D_LAST  input  1  din is the final payload byte of the frame; qualified by D_VALID.
- D_READY  output  1  block accepts din this cycle.
- dout  output  8  output byte (payload or CRC).
- DOUT_VALID  output  1  dout valid.
- DOUT_LAST  output  1  dout is the CRC byte (end of frame).
- DOUT_READY  input  1  downstream accepts dout.
- frames  output  8  count of completed frames (CRC byte accepted downstream); wraps 255->0.

Behaviour:
- Reset (RST=0, async):
  - state=IDLE; crc=INIT.
  - dout=0, DOUT_VALID=0, DOUT_LAST=0, frames=0.
  - D_READY=0 while RST=0.
- Handshakes:
  - Input transfer = D_VALID & D_READY. Output transfer = DOUT_VALID & DOUT_READY.
- Output register:
  - Single register stage; "slot free" = !DOUT_VALID | DOUT_READY.
  - While DOUT_VALID=1 and DOUT_READY=0, dout, DOUT_VALID and DOUT_LAST hold stable.
  - DOUT_VALID never drops without a transfer.
- D_READY:
  - D_READY = (state != CRC) & slot free. Combinational from DOUT_READY; no other input-to-output paths.
- FSM states:
  - IDLE:
    - crc=INIT.
    - On input transfer: load dout=din, DOUT_VALID=1, DOUT_LAST=0; crc=step(INIT,din).
    - Next state is CRC if D_LAST=1, else PAYLOAD.
  - PAYLOAD:
    - On input transfer: dout=din, DOUT_VALID=1, DOUT_LAST=0; crc=step(crc,din).
    - Go to CRC if D_LAST=1.
    - If slot free and no input transfer, DOUT_VALID clears.
  - CRC:
    - Input stalled.
    - When slot free: dout=crc^XOR_OUT, DOUT_VALID=1, DOUT_LAST=1; crc=INIT; go to IDLE.
- Latency: input byte appears on dout 1 cycle after its transfer. CRC byte appears at earliest 1 cycle after the last payload byte's output transfer slot.
- Throughput: 1 byte/cycle within a frame; exactly one input bubble per frame (the CRC cycle).
- CRC step: 8 iterations MSB-first. Each iteration: fb = crc[7]^d[7-i]; crc = {crc[6:0],1'b0} ^ (fb ? POLY : 0).
- frames: increments on output transfer with DOUT_LAST=1.
- Boundary conditions:
  - 1-byte frame (D_LAST on first byte) is legal and yields 2 output bytes.
  - D_LAST while D_VALID=0 is ignored.
  - Zero-length frames are impossible.
  - Back-pressure in CRC state keeps the CRC byte held.
  - Reset mid-frame discards the partial frame; no CRC is emitted.
  - No maximum frame length.

Decomposition:
- Package crc_pkg: CRC8_POLY_DEFAULT=8'h07, state encoding localparams (IDLE=2'd0, PAYLOAD=2'd1, CRC=2'd2).
- Sub-module crc8_byte_step: combinational byte-wise update (inputs crc_in[7:0], d[7:0]; output crc_out[7:0]; parameter POLY).
- Top: FSM, output register, frames counter.

Test Plan:
- Frame "123456789" (8'h31..8'h39, D_LAST on 8'h39), DOUT_READY=1 -> dout sequence 31..39 then 8'hF4 with DOUT_LAST=1; frames=1.
- Single-byte frames 8'h01 then 8'hFF back-to-back -> output 01,07(LAST),FF,F3(LAST). D_READY low for exactly one cycle after each last byte; frames=2.
- Frame "123456789", DOUT_READY toggling pseudo-randomly -> same byte sequence; dout stable whenever DOUT_VALID=1 & DOUT_READY=0; no byte lost or duplicated.
- DOUT_READY=0 held for 10 cycles in CRC state -> dout=8'hF4, DOUT_LAST=1 held; D_READY=0 throughout.
- RST asserted after 3 payload bytes -> DOUT_VALID=0 and frames=0 immediately (async). The next frame 8'h00 (LAST) yields output 00,00; CRC restarts from INIT.
- Parameter XOR_OUT=8'hFF, frame 8'h01 -> CRC byte 8'hF8.
